// File: rtl/gemm_pkg.sv
// Shared types and defaults for the GEMM accumulator buffer.
// Optional feature macro: GEMM_ACC_RELU_EN (ReLU on drained rows).
package gemm_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_ACCUM = 2'b01,
        CMD_DRAIN = 2'b10,
        CMD_NOP   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // One accumulator row; lane widths track DEFAULT_DATA_WIDTH, so the
    // top-level DATA_WIDTH must stay equal to it.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] lane1;
        logic [DEFAULT_DATA_WIDTH-1:0] lane2;
    } acc_row_t;

    // Per-lane ReLU on two's complement lanes: negative lanes become zero.
    function automatic acc_row_t relu_row(input acc_row_t row);
        acc_row_t res;
        res = row;
        if (row.lane1[DEFAULT_DATA_WIDTH-1]) begin
            res.lane1 = '0;
        end else begin
            res.lane1 = row.lane1;
        end
        if (row.lane2[DEFAULT_DATA_WIDTH-1]) begin
            res.lane2 = '0;
        end else begin
            res.lane2 = row.lane2;
        end
        return res;
    endfunction

endpackage

// File: rtl/gemm_acc_regfile.sv
// Accumulator row storage: one synchronous write port, one combinational
// read port, all rows cleared by synchronous reset.
module gemm_acc_regfile
    import gemm_pkg::*;
#(
    parameter int ACC_DEPTH = 16,
    localparam int IDX_W = $clog2(ACC_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  acc_row_t         wdata,
    input  logic [IDX_W-1:0] raddr,
    output acc_row_t         rdata
);

    acc_row_t mem_q [ACC_DEPTH];
    acc_row_t mem_d [ACC_DEPTH];

    // Next row contents: only the addressed row changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Row storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ACC_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/gemm_acc_buffer.sv
// Accumulator buffer closing the GEMM accumulation loop: serves rows to the
// GEMM core, writes results back, clears rows and drains them downstream.
// Optional feature macro: GEMM_ACC_RELU_EN (ReLU applied to drained lanes).
module gemm_acc_buffer
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ACC_DEPTH    = 16,
    parameter int GEMM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(ACC_DEPTH)-1:0] cmd_idx,
    output logic [DATA_WIDTH-1:0]        acc1,
    output logic [DATA_WIDTH-1:0]        acc2,
    input  logic [DATA_WIDTH-1:0]        gemm_result1,
    input  logic [DATA_WIDTH-1:0]        gemm_result2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data1,
    output logic [DATA_WIDTH-1:0]        out_data2,
    output logic                         cmd_done
);

    localparam int         IDX_W    = $clog2(ACC_DEPTH);
    localparam logic [2:0] LAT_INIT = 3'(GEMM_LATENCY);

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  acc1_q, acc1_d;
    logic [DATA_WIDTH-1:0]  acc2_q, acc2_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data1_q, out_data1_d;
    logic [DATA_WIDTH-1:0]  out_data2_q, out_data2_d;
    logic                   cmd_done_q, cmd_done_d;

    logic                   accept_s;
    cmd_op_e                op_s;
    logic                   rf_we_s;
    logic [IDX_W-1:0]       rf_waddr_s;
    acc_row_t               rf_wdata_s;
    acc_row_t               rf_rdata_s;
    acc_row_t               drain_row_s;

    gemm_acc_regfile #(
        .ACC_DEPTH (ACC_DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we_s),
        .waddr (rf_waddr_s),
        .wdata (rf_wdata_s),
        .raddr (cmd_idx),
        .rdata (rf_rdata_s)
    );

    assign op_s      = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept_s  = cmd_valid & cmd_ready;

`ifdef GEMM_ACC_RELU_EN
    assign drain_row_s = relu_row(rf_rdata_s);
`else
    assign drain_row_s = rf_rdata_s;
`endif

    // Command sequencing: next state, row writes and registered output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        out_valid_d = out_valid_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        cmd_done_d  = 1'b0;
        rf_we_s     = 1'b0;
        rf_waddr_s  = idx_q;
        rf_wdata_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    idx_d = cmd_idx;
                    case (op_s)
                        CMD_CLEAR: begin
                            rf_we_s    = 1'b1;
                            rf_waddr_s = cmd_idx;
                            rf_wdata_s = '0;
                            cmd_done_d = 1'b1;
                        end
                        CMD_ACCUM: begin
                            acc1_d  = rf_rdata_s.lane1;
                            acc2_d  = rf_rdata_s.lane2;
                            cnt_d   = LAT_INIT;
                            state_d = ST_WAIT;
                        end
                        CMD_DRAIN: begin
                            out_data1_d = drain_row_s.lane1;
                            out_data2_d = drain_row_s.lane2;
                            out_valid_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end
                        CMD_NOP: begin
                            cmd_done_d = 1'b1;
                        end
                        default: begin
                            cmd_done_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter reaching zero means the GEMM result is now valid.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                rf_we_s          = 1'b1;
                rf_waddr_s       = idx_q;
                rf_wdata_s.lane1 = gemm_result1;
                rf_wdata_s.lane2 = gemm_result2;
                cmd_done_d       = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    cmd_done_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            out_valid_q <= 1'b0;
            out_data1_q <= '0;
            out_data2_q <= '0;
            cmd_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            out_valid_q <= out_valid_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
            cmd_done_q  <= cmd_done_d;
        end
    end

    assign acc1      = acc1_q;
    assign acc2      = acc2_q;
    assign out_valid = out_valid_q;
    assign out_data1 = out_data1_q;
    assign out_data2 = out_data2_q;
    assign cmd_done  = cmd_done_q;

endmodule

// File: tb/tb_gemm_acc_buffer.sv
// Scoreboard bench for gemm_acc_buffer: a driver issues directed and random
// commands against an array model of the rows; a monitor compares drained rows.
module tb_gemm_acc_buffer;
    import gemm_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int LAT   = 1;
    localparam int IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_idx;
    logic [DW-1:0] acc1, acc2;
    logic [DW-1:0] gemm_result1, gemm_result2;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data1, out_data2;
    logic          cmd_done;

    int checks = 0;
    int errors = 0;
    int ready_mode = 2;          // 0 random, 1 forced low, 2 forced high

    acc_row_t model [DEPTH];
    acc_row_t exp_q [$];
    logic [DW-1:0] add1 = '0, add2 = '0;
    logic [DW-1:0] pipe1 [LAT];
    logic [DW-1:0] pipe2 [LAT];

    always #5 clk = ~clk;

    gemm_acc_buffer #(
        .DATA_WIDTH   (DW),
        .ACC_DEPTH    (DEPTH),
        .GEMM_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_idx      (cmd_idx),
        .acc1         (acc1),
        .acc2         (acc2),
        .gemm_result1 (gemm_result1),
        .gemm_result2 (gemm_result2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .cmd_done     (cmd_done)
    );

    // GEMM core model: acc + offset, visible LAT cycles after acc settles.
    always @(posedge clk) begin
        pipe1[0] <= acc1 + add1;
        pipe2[0] <= acc2 + add2;
        for (int i = 1; i < LAT; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign gemm_result1 = pipe1[LAT-1];
    assign gemm_result2 = pipe2[LAT-1];

    // Consumer backpressure, changed just after the active edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic acc_row_t drained(input acc_row_t r);
        acc_row_t x;
        x = r;
`ifdef GEMM_ACC_RELU_EN
        if (r.lane1[DW-1]) x.lane1 = '0;
        if (r.lane2[DW-1]) x.lane2 = '0;
`endif
        return x;
    endfunction

    // Monitor: compare each drained row at its handshake, and hold stability.
    logic [DW-1:0] prev1, prev2;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        acc_row_t e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else if (out_valid) begin
            if (prev_stall) begin
                check("drain_hold_lane1", 32'(out_data1), 32'(prev1));
                check("drain_hold_lane2", 32'(out_data2), 32'(prev2));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("drain_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("drain_lane1", 32'(out_data1), 32'(e.lane1));
                    check("drain_lane2", 32'(out_data2), 32'(e.lane2));
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev1 = out_data1;
                prev2 = out_data2;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Issue one command (called at a negedge) and check its retirement timing.
    task automatic issue(input logic [1:0] op, input int idx, input logic [DW-1:0] a1,
                         input logic [DW-1:0] a2);
        int waitc;
        int lat;
        int exp_lat;
        acc_row_t old;
        add1 = a1;
        add2 = a2;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_idx = IW'(idx);
        waitc = 0;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        old = model[idx];
        exp_lat = -1;
        case (op)
            2'b00: begin model[idx] = '0; exp_lat = 1; end
            2'b01: begin
                model[idx].lane1 = old.lane1 + a1;
                model[idx].lane2 = old.lane2 + a2;
                exp_lat = LAT + 2;
            end
            2'b10: exp_q.push_back(drained(old));
            default: exp_lat = 1;
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(0, 3));
        cmd_idx = IW'($urandom_range(0, DEPTH - 1));
        if (op == 2'b01) begin
            check("accum_acc1", 32'(acc1), 32'(old.lane1));
            check("accum_acc2", 32'(acc2), 32'(old.lane2));
            check("accum_busy_ready", 32'(cmd_ready), 32'd0);
        end
        lat = 1;
        while (!cmd_done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!cmd_done) begin
            fail_now("cmd_done_wait");
        end else if (exp_lat > 0) begin
            check("cmd_done_latency", 32'(lat), 32'(exp_lat));
        end
        @(negedge clk);
        check("cmd_done_pulse", 32'(cmd_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_row_t e;
        int waitc;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b11;
        cmd_idx = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc1", 32'(acc1), 32'd0);
        check("rst_acc2", 32'(acc2), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data1", 32'(out_data1), 32'd0);
        check("rst_out_data2", 32'(out_data2), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        issue(2'b10, 5, 16'h0000, 16'h0000);

        // ACCUM timing and repeated accumulation: row 3 ends at 0x30 / 0x60
        issue(2'b00, 3, 16'h0000, 16'h0000);
        repeat (3) issue(2'b01, 3, 16'h0010, 16'h0020);
        issue(2'b10, 3, 16'h0000, 16'h0000);

        // Drain backpressure
        ready_mode = 1;
        e = drained(model[3]);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_idx = IW'(3);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_data1", 32'(out_data1), 32'(e.lane1));
            check("bp_data2", 32'(out_data2), 32'(e.lane2));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_cmd_done", 32'(cmd_done), 32'd0);
            @(negedge clk);
        end
        ready_mode = 2;
        waitc = 0;
        while (!cmd_done && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_done) begin
            fail_now("bp_cmd_done");
        end else begin
            check("bp_valid_dropped", 32'(out_valid), 32'd0);
            check("bp_ready_back", 32'(cmd_ready), 32'd1);
        end
        @(negedge clk);

        // Index boundaries and wrap
        issue(2'b00, 0, 16'h0000, 16'h0000);
        issue(2'b00, 1, 16'h0000, 16'h0000);
        issue(2'b00, DEPTH - 2, 16'h0000, 16'h0000);
        issue(2'b00, DEPTH - 1, 16'h0000, 16'h0000);
        issue(2'b01, 0, 16'hFFFF, 16'h0001);
        issue(2'b01, DEPTH - 1, 16'h0001, 16'hFFFF);
        issue(2'b01, DEPTH - 1, 16'hFFFF, 16'h0001);
        issue(2'b10, 0, 16'h0000, 16'h0000);
        issue(2'b10, 1, 16'h0000, 16'h0000);
        issue(2'b10, DEPTH - 2, 16'h0000, 16'h0000);
        issue(2'b10, DEPTH - 1, 16'h0000, 16'h0000);

        // ReLU behaviour (raw values when the feature is absent)
        issue(2'b00, 7, 16'h0000, 16'h0000);
        issue(2'b01, 7, 16'h8001, 16'h7FFF);
        issue(2'b10, 7, 16'h0000, 16'h0000);
        issue(2'b10, 7, 16'h0000, 16'h0000);

        // Randomized traffic with random backpressure
        ready_mode = 0;
        for (int n = 0; n < 120; n++) begin
            issue(2'($urandom_range(0, 3)), $urandom_range(0, DEPTH - 1),
                  DW'($urandom), DW'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) issue(2'b10, i, 16'h0000, 16'h0000);

        // Reset during ACCUM wait: no writeback, no cmd_done, rows cleared
        issue(2'b01, 2, 16'h1234, 16'h4321);
        add1 = 16'h0F0F;
        add2 = 16'hF0F0;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_idx = IW'(2);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < 5; i++) begin
            check("midrst_cmd_done", 32'(cmd_done), 32'd0);
            check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
        end
        check("midrst_acc1", 32'(acc1), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) issue(2'b10, i, 16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail_now("drain_missing");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
